// File: rtl/i2s_tx_master_pkg.sv
// I2S frame constants and FSM encoding shared by the transmit master
// and the receive slave.
package i2s_tx_master_pkg;

    localparam int unsigned SLOTS_PER_FRAME = 32;
    localparam int unsigned WS_SWITCH_SLOT  = 16;
    localparam int unsigned SLOT_W          = $clog2(SLOTS_PER_FRAME);
    localparam int unsigned SAMPLE_W        = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

    // Word select is low for the left half-frame, high for the right.
    function automatic logic ws_for_slot(input logic [SLOT_W-1:0] s);
        return (32'(s) >= WS_SWITCH_SLOT);
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: synchronous DEPTH x 32 sample FIFO with registered flags.
// Ports: clk_i/rst_i (sync, active-high), push_i/data_i write side,
// pop_i/data_o show-ahead read side, full_o/empty_o/level_o status.
module i2s_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [31:0]      data_i,
    input  logic             pop_i,
    output logic [31:0]      data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [LVL_W-1:0] cnt_q;
    logic [LVL_W-1:0] cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push on a full
    // FIFO is still accepted when it coincides with a pop.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == LVL_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = cnt_q;

endmodule

// File: rtl/i2s_tx_master.sv
// i2s_tx_master: I2S transmit master fed from a 32-bit stereo FIFO.
// Ports: WB_CLK/WB_RST (sync, active-high); Enable_i run request;
// Sample_Data_i/Sample_Push_i FIFO write; Fifo_Full_o/Fifo_Empty_o/
// Fifo_Level_o status; Underrun_Intr_o sticky, cleared by
// Underrun_Clr_i; I2S_CLK_o/I2S_WS_CLK_o/I2S_DOUT_o serial outputs.
module i2s_tx_master
    import i2s_tx_master_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          WB_CLK,
    input  logic                          WB_RST,
    input  logic                          Enable_i,
    input  logic [SAMPLE_W-1:0]           Sample_Data_i,
    input  logic                          Sample_Push_i,
    input  logic                          Underrun_Clr_i,
    output logic                          Fifo_Full_o,
    output logic                          Fifo_Empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level_o,
    output logic                          Underrun_Intr_o,
    output logic                          I2S_CLK_o,
    output logic                          I2S_WS_CLK_o,
    output logic                          I2S_DOUT_o
);

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

    i2s_state_e          state_q;
    logic [7:0]          div_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [SLOT_W-1:0]   slot_nx;
    logic                clk_q;
    logic                ws_q;
    logic                dout_q;
    logic                stop_q;
    logic                urun_q;
    logic [SAMPLE_W-1:0] shreg_q;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [SAMPLE_W-1:0] load_word;
    logic                fifo_empty;
    logic                div_tc;
    logic                fall;
    logic                frame_end;
    logic                stop;
    logic                pop;
    logic                underrun;

    assign div_tc    = (div_q == DIV_TC);
    assign fall      = (state_q == ST_RUN) && div_tc && clk_q;
    // Falling edge leaving slot 0: frame boundary and pop point.
    assign frame_end = fall && (slot_q == '0);
    // A disable seen at any point in the frame is held until the
    // frame boundary so the right LSB in slot 0 is still sent.
    assign stop      = stop_q || !Enable_i;
    assign pop       = frame_end && !stop;
    assign underrun  = pop && fifo_empty;
    assign slot_nx   = slot_q + SLOT_W'(1);
    assign load_word = fifo_empty ? '0 : fifo_rdata;

    i2s_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (WB_CLK),
        .rst_i   (WB_RST),
        .push_i  (Sample_Push_i),
        .data_i  (Sample_Data_i),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (Fifo_Full_o),
        .empty_o (fifo_empty),
        .level_o (Fifo_Level_o)
    );

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            slot_q  <= '0;
            clk_q   <= 1'b0;
            ws_q    <= 1'b0;
            dout_q  <= 1'b0;
            stop_q  <= 1'b0;
            urun_q  <= 1'b0;
            shreg_q <= '0;
        end else begin
            // Set wins over a coincident clear.
            urun_q <= underrun || (urun_q && !Underrun_Clr_i);
            unique case (state_q)
                ST_IDLE: begin
                    div_q   <= '0;
                    slot_q  <= '0;
                    clk_q   <= 1'b0;
                    ws_q    <= 1'b0;
                    dout_q  <= 1'b0;
                    stop_q  <= 1'b0;
                    shreg_q <= '0;
                    if (Enable_i && !fifo_empty) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!Enable_i) stop_q <= 1'b1;
                    div_q <= div_tc ? 8'd0 : div_q + 8'd1;
                    if (div_tc) clk_q <= ~clk_q;
                    if (fall) begin
                        if (frame_end && stop) begin
                            state_q <= ST_IDLE;
                            slot_q  <= '0;
                            ws_q    <= 1'b0;
                            dout_q  <= 1'b0;
                        end else begin
                            slot_q <= slot_nx;
                            ws_q   <= ws_for_slot(slot_nx);
                            if (frame_end) begin
                                dout_q  <= load_word[SAMPLE_W-1];
                                shreg_q <= {load_word[SAMPLE_W-2:0], 1'b0};
                            end else begin
                                dout_q  <= shreg_q[SAMPLE_W-1];
                                shreg_q <= {shreg_q[SAMPLE_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Fifo_Empty_o    = fifo_empty;
    assign Underrun_Intr_o = urun_q;
    assign I2S_CLK_o       = clk_q;
    assign I2S_WS_CLK_o    = ws_q;
    assign I2S_DOUT_o      = dout_q;

endmodule

// File: doc/i2s_tx_master.md
I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter CLK_DIV, default 4: WB_CLK cycles per I2S_CLK_o half-period; legal range 2..255.
REQ-003 Parameter FIFO_DEPTH, default 8: number of 32-bit sample words; SHALL be a power of two.
REQ-004 WB_CLK  in  1  system clock; all logic on its rising edge.
REQ-005 WB_RST  in  1  synchronous active-high reset.
REQ-006 Enable_i  in  1  transmit enable.
REQ-007 Sample_Data_i  in  32  stereo word: left in [31:16], right in [15:0].
REQ-008 Sample_Push_i  in  1  one-cycle write strobe for Sample_Data_i.
REQ-009 Fifo_Full_o / Fifo_Empty_o  out  1 each  FIFO status flags.
REQ-010 Fifo_Level_o  out  log2(FIFO_DEPTH)+1  current word count.
REQ-011 Underrun_Intr_o  out  1  sticky underrun interrupt.
REQ-012 Underrun_Clr_i  in  1  clears Underrun_Intr_o.
REQ-013 I2S_CLK_o, I2S_WS_CLK_o, I2S_DOUT_o  out  1 each  I2S master bit clock, word select and serial data.

Function
REQ-014 The block SHALL implement states IDLE and RUN; IDLE->RUN when Enable_i=1 and Fifo_Empty_o=0.
REQ-015 In IDLE, I2S_CLK_o, I2S_WS_CLK_o and I2S_DOUT_o SHALL be held at 0, and the divider and slot counters SHALL be held at 0.
REQ-016 In RUN, the divider SHALL count 0..CLK_DIV-1, and I2S_CLK_o SHALL toggle at terminal count, giving a period of 2*CLK_DIV WB_CLK cycles; the first rising edge occurs CLK_DIV cycles after entering RUN.
REQ-017 The 5-bit slot counter s SHALL increment, wrapping 31->0, on each I2S_CLK_o falling edge; RUN begins at s=0.
REQ-018 I2S_WS_CLK_o and I2S_DOUT_o SHALL change only on the cycle on which I2S_CLK_o falls; I2S_WS_CLK_o SHALL be 0 for s=0..15 and 1 for s=16..31.
REQ-019 Data SHALL lag word select by one slot: slot 1 carries the left MSB (bit 31), slot k carries word bit 32-k for k=1..31, and slot 0 carries bit 0 of the previous word.
REQ-020 In the first slot 0 after IDLE, I2S_DOUT_o SHALL be 0.
REQ-021 The FIFO SHALL be popped once per frame, on the falling edge entering s=1, and the popped word SHALL be loaded into the shift register.
REQ-022 If the FIFO is empty at a pop point, the block SHALL transmit an all-zero word and set Underrun_Intr_o the following cycle; framing SHALL continue uninterrupted.
REQ-023 Underrun_Intr_o SHALL stay set until Underrun_Clr_i=1; when set and clear coincide, set SHALL win.
REQ-024 A push while full SHALL be dropped, except when a pop occurs in the same cycle, in which case the push SHALL be accepted and Fifo_Level_o SHALL remain unchanged.
REQ-025 A simultaneous push and pop on an empty FIFO SHALL count as an underrun; the pushed word SHALL be stored and not transmitted this frame.
REQ-026 When Enable_i is deasserted, the block SHALL complete the current frame, including the following slot 0 carrying the right LSB, and then return to IDLE at the end of that slot.
REQ-027 When Enable_i is deasserted, FIFO contents SHALL be retained.
REQ-028 Fifo_Full_o, Fifo_Empty_o and Fifo_Level_o SHALL be registered and SHALL reflect a push or pop on the next cycle.

Reset
REQ-029 On WB_RST=1, the block SHALL go to IDLE, flush the FIFO (Level=0, Empty=1, Full=0), clear Underrun_Intr_o, and drive all I2S outputs to 0 on the next WB_CLK edge, including when reset is asserted mid-frame.
REQ-030 No WB_CLK-derived register SHALL reset asynchronously.

Structure
REQ-031 The I2S frame constants (SLOTS_PER_FRAME=32, WS_SWITCH_SLOT=16, state encodings) SHALL reside in the shared I2S constants package/include, which is also used by the receiver.
REQ-032 The storage SHALL be one sub-module, i2s_tx_fifo: a synchronous FIFO_DEPTH x 32 FIFO with push, pop, full, empty and level.
REQ-033 I2S_CLK_o SHALL be driven from a register and SHALL NOT pass through gated logic.

Verification
REQ-034 CLK_DIV=4; push 32'hA5A5_3C3C; Enable_i=1 -> I2S_CLK_o period is 8 cycles; slots 1..16 carry 1010010110100101 with WS=0; slots 17..31 plus the next slot 0 carry 0011110000111100 with WS=1 for slots 16..31.
REQ-035 Push 2 words, keep enabled for 3 frames -> frame 3 transmits zeros, Underrun_Intr_o=1 one cycle after the frame-3 pop; Underrun_Clr_i pulse -> 0.
REQ-036 Push 9 words with FIFO_DEPTH=8 while IDLE -> Level=8, Full=1, 9th word dropped; then enable and push on the pop cycle -> Level stays 8.
REQ-037 Deassert Enable_i at s=5 -> outputs continue to the next slot 0 (right LSB emitted), then IDLE with all outputs 0; remaining FIFO Level unchanged.
REQ-038 Assert WB_RST at s=20 -> next cycle all outputs 0, Level=0, Underrun_Intr_o=0, state IDLE.
REQ-039 Loopback: drive I2S_CLK_o, I2S_WS_CLK_o and I2S_DOUT_o into the existing I2S slave receiver -> 16 random words are received bit-exact in order.
